dmem_arbiter: RTL

- Shares one single-port data memory between two requesters: the CPU pipeline's execute/memory stage (port C) and the ring network interface (port N).
- Sits between the core's memory outputs and the data-memory macro.
- Arbitrates each cycle using round-robin, drives the memory strobes, and tracks in-flight reads so read data returns to the correct requester.
- Produces a stall to the CPU when a CPU access is not granted.

---
 rtl/dmem_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that shares one single-port data memory between the CPU (C) and the NIC (N).
// Read returns are routed back to their requester through a MEM_LAT-deep {valid, owner} pipeline.
module dmem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_wrEn,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_stall,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              n_req,
  input  logic              n_wrEn,
  input  logic [ADDR_W-1:0] n_addr,
  input  logic [DATA_W-1:0] n_wdata,
  output logic              n_gnt,
  output logic              n_rvalid,
  output logic [DATA_W-1:0] n_rdata,
  output logic              memEn,
  output logic              memWrEn,
  output logic [ADDR_W-1:0] addr_out,
  output logic [DATA_W-1:0] d_out,
  input  logic [DATA_W-1:0] d_in
);

  localparam logic PORT_C = 1'b0;
  localparam logic PORT_N = 1'b1;
  localparam int   TAIL   = MEM_LAT - 1;

  logic               last_gnt_q, last_gnt_d;
  logic [MEM_LAT-1:0] vld_q, vld_d;
  logic [MEM_LAT-1:0] own_q, own_d;
  logic               gnt_c, gnt_n;

  // Under contention the port that did not win last time goes first.
  always_comb begin
    gnt_c = 1'b0;
    gnt_n = 1'b0;
    if (!reset) begin
      if (c_req && n_req) begin
        gnt_c = (last_gnt_q == PORT_N);
        gnt_n = ~gnt_c;
      end else begin
        gnt_c = c_req;
        gnt_n = n_req;
      end
    end
  end

  always_comb begin
    memEn    = 1'b0;
    memWrEn  = 1'b0;
    addr_out = '0;
    d_out    = '0;
    if (gnt_c) begin
      memEn    = 1'b1;
      memWrEn  = c_wrEn;
      addr_out = c_addr;
      d_out    = c_wdata;
    end else if (gnt_n) begin
      memEn    = 1'b1;
      memWrEn  = n_wrEn;
      addr_out = n_addr;
      d_out    = n_wdata;
    end
  end

  always_comb begin
    last_gnt_d = last_gnt_q;
    if (gnt_c) begin
      last_gnt_d = PORT_C;
    end else if (gnt_n) begin
      last_gnt_d = PORT_N;
    end
  end

  always_comb begin
    vld_d    = '0;
    own_d    = '0;
    vld_d[0] = memEn & ~memWrEn;
    own_d[0] = gnt_n & ~n_wrEn;
    for (int i = 1; i < MEM_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      own_d[i] = own_q[i-1];
    end
  end

  // Reset gating keeps a return that lands in the reset cycle from escaping.
  always_comb begin
    c_rvalid = ~reset & vld_q[TAIL] & (own_q[TAIL] == PORT_C);
    n_rvalid = ~reset & vld_q[TAIL] & (own_q[TAIL] == PORT_N);
    c_rdata  = c_rvalid ? d_in : '0;
    n_rdata  = n_rvalid ? d_in : '0;
    c_gnt    = gnt_c;
    n_gnt    = gnt_n;
    c_stall  = c_req & ~gnt_c & ~reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_gnt_q <= PORT_N;
      vld_q      <= '0;
      own_q      <= '0;
    end else begin
      last_gnt_q <= last_gnt_d;
      vld_q      <= vld_d;
      own_q      <= own_d;
    end
  end

endmodule
